// File: rtl/ibex_pkg.sv
// Shared types for the register-file write arbiter: the write request record,
// the per-cycle grant encoding and the RV32E destination legality check.
package ibex_pkg;

    localparam int unsigned RfAddrWidth = 5;
    localparam int unsigned RfDataWidth = 32;

    typedef struct packed {
        logic [RfAddrWidth-1:0] waddr;
        logic [RfDataWidth-1:0] wdata;
    } rf_wr_req_t;

    typedef enum logic [1:0] {
        GrantNone = 2'd0,
        GrantEx   = 2'd1,
        GrantLsu  = 2'd2
    } grant_e;

    // x16..x31 do not exist on an RV32E core
    function automatic logic waddr_illegal(input logic [RfAddrWidth-1:0] waddr,
                                           input logic                   rv32e);
        return rv32e & waddr[RfAddrWidth-1];
    endfunction

endpackage

// File: rtl/ibex_rf_wr_fifo.sv
// Load-response buffer for the write arbiter. Pointers wrap modulo Depth, so
// non-power-of-two depths are fine. Every entry's destination and valid bit is
// exposed so the arbiter can compare them against ID read addresses.
module ibex_rf_wr_fifo
    import ibex_pkg::*;
#(
    parameter  int unsigned Depth     = 2,
    parameter  int unsigned DataWidth = 32,
    localparam int unsigned CntW      = $clog2(Depth + 1),
    localparam int unsigned PtrW      = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               push_i,
    input  logic [RfAddrWidth-1:0]             push_waddr_i,
    input  logic [DataWidth-1:0]               push_wdata_i,
    input  logic                               pop_i,
    output logic [RfAddrWidth-1:0]             head_waddr_o,
    output logic [DataWidth-1:0]               head_wdata_o,
    output logic                               empty_o,
    output logic                               full_o,
    output logic [CntW-1:0]                    count_o,
    output logic [Depth-1:0][RfAddrWidth-1:0]  entry_waddr_o,
    output logic [Depth-1:0]                   entry_valid_o
);

    logic [Depth-1:0][RfAddrWidth-1:0] waddr_q;
    logic [DataWidth-1:0]              wdata_q [Depth];
    logic [Depth-1:0]                  valid_q;
    logic [PtrW-1:0]                   wr_ptr_q;
    logic [PtrW-1:0]                   rd_ptr_q;
    logic [CntW-1:0]                   count_q;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    // Entry payload; no reset needed since valid_q qualifies every use
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            waddr_q[wr_ptr_q] <= push_waddr_i;
            wdata_q[wr_ptr_q] <= push_wdata_i;
        end
    end

    // Pointers, occupancy and per-entry valid bits
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (push_i) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= ptr_next(wr_ptr_q);
            end
            if (pop_i) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= ptr_next(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_waddr_o  = waddr_q[rd_ptr_q];
    assign head_wdata_o  = wdata_q[rd_ptr_q];
    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == CntW'(Depth));
    assign count_o       = count_q;
    assign entry_waddr_o = waddr_q;
    assign entry_valid_o = valid_q;

endmodule

// File: rtl/ibex_rf_write_arbiter.sv
// Register-file write port arbiter: merges EX results and buffered LSU load
// responses into one registered write per cycle, alternating fairly when both
// contend, and flags read-after-write hazards towards ID.
// Optional feature macro: IBEX_RF_WRARB_BYPASS_EN (forward the output stage
// to ID instead of stalling on it).
module ibex_rf_write_arbiter
    import ibex_pkg::*;
#(
    parameter  int unsigned DataWidth    = 32,
    parameter  bit          RV32E        = 1'b0,
    parameter  int unsigned LsuFifoDepth = 2,
    localparam int unsigned PendW        = $clog2(LsuFifoDepth + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ex_valid_i,
    input  logic [RfAddrWidth-1:0] ex_waddr_i,
    input  logic [DataWidth-1:0]   ex_wdata_i,
    output logic                   ex_ready_o,
    input  logic                   lsu_valid_i,
    input  logic [RfAddrWidth-1:0] lsu_waddr_i,
    input  logic [DataWidth-1:0]   lsu_wdata_i,
    output logic                   lsu_ready_o,
    output logic [RfAddrWidth-1:0] rf_waddr_o,
    output logic [DataWidth-1:0]   rf_wdata_o,
    output logic                   rf_we_o,
    input  logic [RfAddrWidth-1:0] id_raddr_a_i,
    input  logic [RfAddrWidth-1:0] id_raddr_b_i,
    output logic                   id_hazard_o,
    output logic                   fwd_a_valid_o,
    output logic                   fwd_b_valid_o,
    output logic [DataWidth-1:0]   fwd_data_o,
    output logic [PendW-1:0]       pending_o,
    output logic                   err_o
);

    logic                                     fifo_empty;
    logic                                     fifo_full;
    logic [RfAddrWidth-1:0]                   head_waddr;
    logic [DataWidth-1:0]                     head_wdata;
    logic [LsuFifoDepth-1:0][RfAddrWidth-1:0] entry_waddr;
    logic [LsuFifoDepth-1:0]                  entry_valid;
    logic                                     last_lsu_q;
    grant_e                                   grant;
    logic [RfAddrWidth-1:0]                   sel_waddr;
    logic [DataWidth-1:0]                     sel_wdata;
    logic                                     sel_illegal;
    logic                                     fifo_match_a;
    logic                                     fifo_match_b;
    logic                                     out_match_a;
    logic                                     out_match_b;

    // Readiness depends only on registered occupancy, never on this cycle's pop
    assign lsu_ready_o = !fifo_full;

    ibex_rf_wr_fifo #(
        .Depth     (LsuFifoDepth),
        .DataWidth (DataWidth)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (lsu_valid_i && !fifo_full),
        .push_waddr_i  (lsu_waddr_i),
        .push_wdata_i  (lsu_wdata_i),
        .pop_i         (grant == GrantLsu),
        .head_waddr_o  (head_waddr),
        .head_wdata_o  (head_wdata),
        .empty_o       (fifo_empty),
        .full_o        (fifo_full),
        .count_o       (pending_o),
        .entry_waddr_o (entry_waddr),
        .entry_valid_o (entry_valid)
    );

    // Round-robin grant; a full FIFO wins outright so loads cannot back up
    always_comb begin
        grant = GrantNone;
        if (!fifo_empty && (fifo_full || !last_lsu_q || !ex_valid_i)) begin
            grant = GrantLsu;
        end else if (ex_valid_i) begin
            grant = GrantEx;
        end
    end

    assign ex_ready_o  = ex_valid_i && (grant == GrantEx);
    assign sel_waddr   = (grant == GrantLsu) ? head_waddr : ex_waddr_i;
    assign sel_wdata   = (grant == GrantLsu) ? head_wdata : ex_wdata_i;
    assign sel_illegal = waddr_illegal(sel_waddr, RV32E);

    // Output stage: one registered write per cycle; x0 and illegal targets are swallowed
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            err_o      <= 1'b0;
            last_lsu_q <= 1'b0;
        end else begin
            rf_we_o <= 1'b0;
            err_o   <= 1'b0;
            if (grant != GrantNone) begin
                rf_waddr_o <= sel_waddr;
                rf_wdata_o <= sel_wdata;
                rf_we_o    <= (sel_waddr != '0) && !sel_illegal;
                err_o      <= sel_illegal;
                last_lsu_q <= (grant == GrantLsu);
            end
        end
    end

    // Compare ID read addresses against every buffered load destination
    always_comb begin
        fifo_match_a = 1'b0;
        fifo_match_b = 1'b0;
        for (int unsigned i = 0; i < LsuFifoDepth; i++) begin
            if (entry_valid[i] && (entry_waddr[i] == id_raddr_a_i)) fifo_match_a = 1'b1;
            if (entry_valid[i] && (entry_waddr[i] == id_raddr_b_i)) fifo_match_b = 1'b1;
        end
        fifo_match_a = fifo_match_a && (id_raddr_a_i != '0);
        fifo_match_b = fifo_match_b && (id_raddr_b_i != '0);
    end

    assign out_match_a = rf_we_o && (id_raddr_a_i != '0) && (rf_waddr_o == id_raddr_a_i);
    assign out_match_b = rf_we_o && (id_raddr_b_i != '0) && (rf_waddr_o == id_raddr_b_i);

`ifdef IBEX_RF_WRARB_BYPASS_EN
    assign id_hazard_o   = fifo_match_a || fifo_match_b;
    assign fwd_a_valid_o = out_match_a;
    assign fwd_b_valid_o = out_match_b;
    assign fwd_data_o    = rf_wdata_o;
`else
    assign id_hazard_o   = fifo_match_a || fifo_match_b || out_match_a || out_match_b;
    assign fwd_a_valid_o = 1'b0;
    assign fwd_b_valid_o = 1'b0;
    assign fwd_data_o    = '0;
`endif

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Bench for ibex_rf_write_arbiter: a per-cycle vector table with expected
// combinational outputs and expected writes (queued at drive time, popped one
// cycle later), plus directed RV32E and reset sequences.
module tb_ibex_rf_write_arbiter;
    import ibex_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_waddr = '0;
    logic [31:0] ex_wdata = '0;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_waddr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [4:0]  raddr_a = '0;
    logic [4:0]  raddr_b = '0;

    logic        ex_ready, lsu_ready, rf_we, hazard, fwd_a, fwd_b, err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, fwd_data;
    logic [1:0]  pending;

    logic        e_ex_ready, e_lsu_ready, e_rf_we, e_hazard, e_fwd_a, e_fwd_b, e_err;
    logic [4:0]  e_rf_waddr;
    logic [31:0] e_rf_wdata, e_fwd_data;
    logic [1:0]  e_pending;

    ibex_rf_write_arbiter #(.DataWidth(32), .RV32E(1'b0), .LsuFifoDepth(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready),
        .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(lsu_ready),
        .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .rf_we_o(rf_we),
        .id_raddr_a_i(raddr_a), .id_raddr_b_i(raddr_b), .id_hazard_o(hazard),
        .fwd_a_valid_o(fwd_a), .fwd_b_valid_o(fwd_b), .fwd_data_o(fwd_data),
        .pending_o(pending), .err_o(err)
    );

    ibex_rf_write_arbiter #(.DataWidth(32), .RV32E(1'b1), .LsuFifoDepth(2)) dut_e (
        .clk_i(clk), .rst_i(rst),
        .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(e_ex_ready),
        .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(e_lsu_ready),
        .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata), .rf_we_o(e_rf_we),
        .id_raddr_a_i(raddr_a), .id_raddr_b_i(raddr_b), .id_hazard_o(e_hazard),
        .fwd_a_valid_o(e_fwd_a), .fwd_b_valid_o(e_fwd_b), .fwd_data_o(e_fwd_data),
        .pending_o(e_pending), .err_o(e_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        x_exr;
        logic        x_lsr;
        logic        x_haz;
        int          x_pend;
        logic        x_we;
        logic [4:0]  x_wa;
        logic [31:0] x_wd;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        err;
    } wr_t;

    vec_t tbl[$];
    wr_t  sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                                input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                input logic [4:0] ra, input logic [4:0] rb,
                                input logic exr, input logic lsr, input logic haz, input int pend,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd);
        vec_t v;
        v.ev = ev; v.ea = ea; v.ed = ed; v.lv = lv; v.la = la; v.ld = ld;
        v.ra = ra; v.rb = rb; v.x_exr = exr; v.x_lsr = lsr; v.x_haz = haz;
        v.x_pend = pend; v.x_we = we; v.x_wa = wa; v.x_wd = wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ex_valid  = v.ev; ex_waddr  = v.ea; ex_wdata  = v.ed;
        lsu_valid = v.lv; lsu_waddr = v.la; lsu_wdata = v.ld;
        raddr_a   = v.ra; raddr_b   = v.rb;
    endtask

    task automatic check_out(input string tag);
        wr_t w;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end else begin
            w = sb_q.pop_front();
            chk({tag, " rf_we"}, 32'(rf_we), 32'(w.we));
            if (w.we) begin
                chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(w.wa));
                chk({tag, " rf_wdata"}, rf_wdata, w.wd);
            end
            chk({tag, " err"}, 32'(err), 32'(w.err));
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        wr_t w;
        @(negedge clk);
        drive(v);
        #1;
        chk({tag, " ex_ready"},  32'(ex_ready),  32'(v.x_exr));
        chk({tag, " lsu_ready"}, 32'(lsu_ready), 32'(v.x_lsr));
        chk({tag, " hazard"},    32'(hazard),    32'(v.x_haz));
        chk({tag, " pending"},   32'(pending),   32'(v.x_pend));
        chk({tag, " fwd"},       {fwd_data[29:0], fwd_a, fwd_b}, 32'd0);
        w.we = v.x_we; w.wa = v.x_wa; w.wd = v.x_wd; w.err = 1'b0;
        sb_q.push_back(w);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        idle = mk(0,0,0, 0,0,0, 0,0, 0,1,0,0, 0,0,0);

        // EX only, then output-stage hazard
        tbl.push_back(mk(1,5,32'h1234, 0,0,0,          0,0,   1,1,0,0, 1,5,32'h1234));
        tbl.push_back(mk(0,0,0,        0,0,0,          5,0,   0,1,1,0, 0,0,0));
        // contention: x6 loads vs x7 EX results every cycle
        tbl.push_back(mk(1,7,32'hBBBB, 1,6,32'hAAAA,   0,0,   1,1,0,0, 1,7,32'hBBBB));
        tbl.push_back(mk(1,7,32'hBBBB, 1,6,32'hAAAA,   0,0,   0,1,0,1, 1,6,32'hAAAA));
        tbl.push_back(mk(1,7,32'hBBBB, 1,6,32'hAAAA,   0,0,   1,1,0,1, 1,7,32'hBBBB));
        tbl.push_back(mk(1,7,32'hBBBB, 1,6,32'hAAAA,   0,0,   0,0,0,2, 1,6,32'hAAAA));
        tbl.push_back(mk(1,7,32'hBBBB, 1,6,32'hAAAA,   0,0,   1,1,0,1, 1,7,32'hBBBB));
        tbl.push_back(mk(1,7,32'hBBBB, 1,6,32'hAAAA,   0,0,   0,0,0,2, 1,6,32'hAAAA));
        tbl.push_back(mk(0,0,0,        0,0,0,          6,0,   0,1,1,1, 1,6,32'hAAAA));
        tbl.push_back(mk(0,0,0,        0,0,0,          0,0,   0,1,0,0, 0,0,0));
        // full FIFO with EX continuously valid
        tbl.push_back(mk(1,3,32'h3333, 1,9,32'h9999,   9,0,   1,1,0,0, 1,3,32'h3333));
        tbl.push_back(mk(1,3,32'h3334, 1,10,32'hA0A0,  9,0,   0,1,1,1, 1,9,32'h9999));
        tbl.push_back(mk(1,3,32'h3334, 1,11,32'hB0B0,  9,10,  1,1,1,1, 1,3,32'h3334));
        tbl.push_back(mk(1,3,32'h3335, 1,12,32'hC0C0,  11,0,  0,0,1,2, 1,10,32'hA0A0));
        tbl.push_back(mk(1,3,32'h3335, 1,12,32'hC0C0,  0,0,   1,1,0,1, 1,3,32'h3335));
        tbl.push_back(mk(0,0,0,        0,0,0,          12,0,  0,0,1,2, 1,11,32'hB0B0));
        tbl.push_back(mk(0,0,0,        0,0,0,          0,0,   0,1,0,1, 1,12,32'hC0C0));
        tbl.push_back(mk(0,0,0,        0,0,0,          0,12,  0,1,1,0, 0,0,0));
        // x0 destinations from both sources
        tbl.push_back(mk(1,0,32'hDEAD, 1,0,32'hBEEF,   0,0,   1,1,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,        0,0,0,          0,0,   0,1,0,1, 0,0,0));
        tbl.push_back(mk(0,0,0,        0,0,0,          0,0,   0,1,0,0, 0,0,0));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset rf_we",     32'(rf_we),     32'd0);
        chk("reset rf_waddr",  32'(rf_waddr),  32'd0);
        chk("reset rf_wdata",  rf_wdata,       32'd0);
        chk("reset err",       32'(err),       32'd0);
        chk("reset pending",   32'(pending),   32'd0);
        chk("reset lsu_ready", 32'(lsu_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("v%0d", i));
        end

        // RV32E: EX write to x20 is dropped with a one-cycle error pulse
        @(negedge clk);
        drive(mk(1,20,32'h2020, 0,0,0, 0,0, 0,0,0,0, 0,0,0));
        #1;
        chk("rv32e ex_ready",       32'(e_ex_ready), 32'd1);
        chk("rv32i ex_ready",       32'(ex_ready),   32'd1);
        @(posedge clk); #1;
        chk("rv32e x20 rf_we",      32'(e_rf_we),    32'd0);
        chk("rv32e x20 err",        32'(e_err),      32'd1);
        chk("rv32i x20 rf_we",      32'(rf_we),      32'd1);
        chk("rv32i x20 rf_waddr",   32'(rf_waddr),   32'd20);
        chk("rv32i x20 err",        32'(err),        32'd0);
        @(negedge clk);
        drive(idle);
        @(posedge clk); #1;
        chk("rv32e err pulse end",  32'(e_err),      32'd0);
        chk("rv32e idle rf_we",     32'(e_rf_we),    32'd0);

        // RV32E: buffered load to x17 errors when it drains
        @(negedge clk);
        drive(mk(0,0,0, 1,17,32'h1717, 0,0, 0,0,0,0, 0,0,0));
        @(posedge clk); #1;
        chk("rv32e lsu push pending", 32'(e_pending), 32'd1);
        chk("rv32e lsu push err",     32'(e_err),     32'd0);
        @(negedge clk);
        drive(idle);
        @(posedge clk); #1;
        chk("rv32e x17 rf_we",      32'(e_rf_we),    32'd0);
        chk("rv32e x17 err",        32'(e_err),      32'd1);
        chk("rv32i x17 rf_we",      32'(rf_we),      32'd1);
        chk("rv32i x17 rf_waddr",   32'(rf_waddr),   32'd17);
        @(negedge clk);
        @(posedge clk); #1;
        chk("rv32e x17 err end",    32'(e_err),      32'd0);

        // Reset with two loads buffered: they must never be written
        step(mk(1,13,32'h1313, 1,14,32'h1414, 0,0, 1,1,0,0, 1,13,32'h1313), "s0");
        step(mk(1,13,32'h1314, 1,15,32'h1515, 0,0, 0,1,0,1, 1,14,32'h1414), "s1");
        step(mk(1,13,32'h1315, 1,16,32'h1616, 0,0, 1,1,0,1, 1,13,32'h1315), "s2");
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        #1;
        chk("pre-reset pending",    32'(pending),    32'd2);
        chk("pre-reset lsu_ready",  32'(lsu_ready),  32'd0);
        @(posedge clk); #1;
        chk("mid reset pending",    32'(pending),    32'd0);
        chk("mid reset rf_we",      32'(rf_we),      32'd0);
        chk("mid reset rf_waddr",   32'(rf_waddr),   32'd0);
        chk("mid reset rf_wdata",   rf_wdata,        32'd0);
        chk("mid reset lsu_ready",  32'(lsu_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(idle, $sformatf("post-reset%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_rf_write_arbiter.md
Name: ibex_rf_write_arbiter

Overview:
- Sits directly upstream of the register file write port W1; merges EX-stage results and LSU load responses into one registered write per cycle.
- Buffers load responses in a small FIFO and arbitrates fairly between the FIFO and EX.
- Tracks in-flight destinations and raises a read-after-write hazard flag towards ID, since the register file has no internal bypass.

Parameters:
- DataWidth, 32, width of write data.
- RV32E, 0, when 1 only x0-x15 are legal destinations.
- LsuFifoDepth, 2, load-response FIFO entries (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- ex_valid_i  in  1  EX result valid.
- ex_waddr_i  in  5  EX destination register.
- ex_wdata_i  in  DataWidth  EX result.
- ex_ready_o  out  1  EX result accepted this cycle.
- lsu_valid_i  in  1  load response valid.
- lsu_waddr_i  in  5  load destination register.
- lsu_wdata_i  in  DataWidth  load data.
- lsu_ready_o  out  1  FIFO can accept.
- rf_waddr_o  out  5  to register file waddr_a_i.
- rf_wdata_o  out  DataWidth  to register file wdata_a_i.
- rf_we_o  out  1  to register file we_a_i.
- id_raddr_a_i  in  5  ID read address A.
- id_raddr_b_i  in  5  ID read address B.
- id_hazard_o  out  1  ID must stall.
- fwd_a_valid_o  out  1  forward available for A.
- fwd_b_valid_o  out  1  forward available for B.
- fwd_data_o  out  DataWidth  forwarded value (output stage data).
- pending_o  out  $clog2(LsuFifoDepth+1)  FIFO occupancy.
- err_o  out  1  illegal-destination pulse.

Behaviour:
- Reset: FIFO emptied; rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, err_o=0, pending_o=0; last-grant flag=EX. Reset mid-operation drops all buffered loads silently.
- LSU push when lsu_valid_i && lsu_ready_o. lsu_ready_o = !full, from registered state only; a full FIFO never accepts, even with a same-cycle pop.
- Grant each cycle:
  - FIFO if non-empty && (full || last grant==EX || !ex_valid_i).
  - Otherwise EX if ex_valid_i.
  - Otherwise none.
- ex_ready_o = ex_valid_i && EX granted. last grant updates only on a real grant.
- Output stage is a register with 1-cycle latency. The granted entry loads into rf_waddr_o/rf_wdata_o; rf_we_o=1 next cycle. With no grant, rf_we_o=0 next cycle.
- x0 destination: handshake completes, rf_we_o=0.
- RV32E && waddr[4]=1: handshake completes, write dropped, err_o=1 for exactly one cycle, registered.
- Hazard: id_hazard_o=1 if a nonzero id_raddr_a/b_i matches any valid FIFO entry. Without bypass it is also set on a match with the output stage while rf_we_o=1. Combinational from state and ID inputs.
- FIFO pointers wrap modulo LsuFifoDepth. Occupancy counts 0..LsuFifoDepth. Push and pop in the same cycle leave the count unchanged.

Optional Feature:
- IBEX_RF_WRARB_BYPASS_EN defined:
  - An output-stage match (rf_we_o=1, nonzero address equal to id_raddr_x) is not a hazard.
  - fwd_a/b_valid_o=1 and fwd_data_o=rf_wdata_o.
  - FIFO matches still stall.
- Undefined: fwd_*_valid_o tied 0, fwd_data_o tied 0, output-stage matches stall.

Decomposition:
- ibex_pkg: rf_wr_req_t struct {waddr[4:0], wdata[DataWidth-1:0]}; grant enum {GrantNone, GrantEx, GrantLsu}.
- Sub-module ibex_rf_wr_fifo: parameterised depth, push/pop, occupancy, and per-entry address/valid exposure for the hazard compare.

Test Plan:
- EX only: ex write x5=0x1234 → next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234; ex_ready_o=1 in the request cycle.
- Contention: LSU x6=0xAAAA and EX x7=0xBBBB every cycle → grants alternate; FIFO drains with no starvation; pending_o never exceeds 2.
- Full FIFO: 2 loads with EX continuously valid → lsu_ready_o=0; next grant is FIFO; lsu_ready_o returns 1 the cycle after the pop.
- Hazard: FIFO holds x9 and ID reads x9 → id_hazard_o=1. ID reads x0 with a pending x0 write → id_hazard_o=0.
- RV32E=1: EX writes x20 → rf_we_o=0, err_o pulses exactly 1 cycle, ex_ready_o=1.
- Reset asserted with 2 loads buffered → next cycle pending_o=0, rf_we_o=0, and no write ever occurs for those entries.
